shift_sub_div: RTL
==================

Name: shift_sub_div

Overview:
- Sequential restoring shift-subtract divider. Produces one quotient bit per enabled clock.
- It is the inverse companion of the team's 512-bit shift-add multiply-accumulate datapath. It divides a 2N-bit dividend (for example, a MAC result) by an N-bit divisor.
- It returns a 2N-bit quotient and an N-bit remainder.
- It uses a start/busy/done handshake, so a controller can chain it after the MAC.

Parameters:
- N, 256, divisor and remainder width. Dividend and quotient width is 2N.
- CW, 10, iteration counter width. Must satisfy 2^CW > 2N.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- en  input  1  global clock enable; when low, all state is frozen
- start  input  1  request a new division; sampled only in IDLE with en=1
- dividend  input  2N  numerator, latched on accepted start
- divisor  input  N  denominator, latched on accepted start
- busy  output  1  high in RUN and DONE
- done  output  1  high for exactly one enabled cycle (DONE state)
- div_zero  output  1  set when the latched divisor was 0; valid while done=1, held until next start
- quotient  output  2N  result; held until the next accepted start
- remainder  output  N  result; held until the next accepted start

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: state=IDLE, counter=0, busy=0, done=0, div_zero=0, quotient=0, remainder=0, internal operand registers=0.
- Reset asserted mid-operation aborts immediately to these values. No result is produced.
- en=0: no state, counter or output register changes, including inside RUN and DONE. A done pulse is stretched while en is low.
- States: IDLE, RUN, DONE. Only enabled edges count in the rules below.
- IDLE:
  - If start=1, latch dividend into the shift register and divisor into its register.
  - Clear the partial remainder (N+1 bits) and set counter=0.
  - If divisor==0, go to DONE with quotient=all ones, remainder=dividend[N-1:0], div_zero=1.
  - Otherwise clear div_zero and go to RUN.
  - If start=0, stay in IDLE.
- RUN, one iteration per edge:
  - trial = {partial[N-1:0], dividend_sr[2N-1]} - {1'b0, divisor}, computed at N+1 bits.
  - If trial is non-negative (MSB=0): partial<=trial and shift 1 into the quotient LSB.
  - Else: partial<={partial[N-1:0], dividend_sr[2N-1]} and shift 0 into the quotient LSB.
  - The dividend shift register shifts left by 1 each iteration.
  - When counter==2N-1, go to DONE; otherwise counter+1.
- DONE: done=1 and busy=1. On the next edge, go to IDLE with done=0 and busy=0.
- Latency: start accepted on edge E0; done=1 after edge E2N; back in IDLE after edge E2N+1. That is 2N+2 enabled edges per operation. A divide-by-zero takes 2 enabled edges.
- Simultaneous events:
  - start while busy is ignored; it is not queued.
  - start in the same cycle the block leaves DONE is ignored. The block accepts start only once it is in IDLE.
  - Operand changes while busy have no effect.
- Back-to-back operation: start held high continuously yields one operation every 2N+2 enabled edges.
- Arithmetic:
  - Unsigned only. Remainder is always < divisor.
  - Invariant: quotient*divisor + remainder == dividend, computed at 3N bits, whenever div_zero=0.

Decomposition:
- Shared package (div_pkg):
  - state encoding localparams S_IDLE=2'd0, S_RUN=2'd1, S_DONE=2'd2;
  - default N and CW constants.
- Sub-module div_sub_stage: combinational (N+1)-bit conditional subtractor.
  - Inputs: shifted partial remainder and divisor.
  - Outputs: next partial remainder and quotient bit.
  - Instantiated once. It can later be swapped for a CLA-based subtractor without touching the FSM.

Test Plan:
- N=8: dividend=16'd1000, divisor=8'd7, start one cycle -> done after edge 16 with quotient=142, remainder=6, div_zero=0. busy high for edges 0-17.
- N=8: divisor=0, dividend=16'h1234 -> done after 1 edge with quotient=16'hFFFF, remainder=8'h34, div_zero=1.
- N=8: dividend=16'hFFFF, divisor=8'h01 -> quotient=16'hFFFF, remainder=0. Also dividend=5, divisor=200 -> quotient=0, remainder=5.
- N=8: toggle en low for 5 cycles mid-RUN, and pulse start while busy -> same result as the first case, done delayed by 5 cycles, no second operation started.
- N=8: assert rst at RUN iteration 7 -> all outputs 0 immediately (asynchronously). A subsequent start gives a correct fresh result.
- N=256 default: random 512/256-bit operands plus divisor=2^256-1, dividend=2^512-1, over 200 back-to-back operations -> invariant holds for every result, with done every 514 enabled edges.

Source files
------------

// File: rtl/div_pkg.sv
// Shared constants and state encoding for the shift-subtract divider.
package div_pkg;

    localparam int unsigned DEF_N  = 256;
    localparam int unsigned DEF_CW = 10;

    typedef logic [1:0] state_t;

    localparam state_t S_IDLE = 2'd0;
    localparam state_t S_RUN  = 2'd1;
    localparam state_t S_DONE = 2'd2;

endpackage

// File: rtl/div_sub_stage.sv
// One restoring-division step: conditional subtract of the divisor from the shifted partial.
module div_sub_stage
    import div_pkg::*;
#(
    parameter int unsigned N = DEF_N
) (
    input  logic [N:0]   shifted,
    input  logic [N-1:0] divisor,
    output logic [N-1:0] partial_next,
    output logic         q_bit
);

    logic [N:0] trial;

    // A restored partial is always below the divisor, so its top bit is zero and is dropped.
    always_comb begin
        trial        = shifted - {1'b0, divisor};
        q_bit        = ~trial[N];
        partial_next = q_bit ? trial[N-1:0] : shifted[N-1:0];
    end

endmodule

// File: rtl/shift_sub_div.sv
// Sequential restoring divider: 2N-bit dividend / N-bit divisor, one quotient bit per enabled edge.
module shift_sub_div
    import div_pkg::*;
#(
    parameter int unsigned N  = DEF_N,
    parameter int unsigned CW = DEF_CW
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    input  logic           start,
    input  logic [2*N-1:0] dividend,
    input  logic [N-1:0]   divisor,
    output logic           busy,
    output logic           done,
    output logic           div_zero,
    output logic [2*N-1:0] quotient,
    output logic [N-1:0]   remainder
);

    localparam logic [CW-1:0] LastIter = CW'(2 * N - 1);

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2*N-1:0] dvd_sr_q, dvd_sr_d;
    logic [N-1:0]   dvs_q, dvs_d;
    logic [N-1:0]   part_q, part_d;
    logic [2*N-1:0] quot_q, quot_d;
    logic [N-1:0]   rem_q, rem_d;
    logic           dz_q, dz_d;

    logic [N:0]     shifted;
    logic [N-1:0]   part_next;
    logic           q_bit;

    assign shifted = {part_q, dvd_sr_q[2*N-1]};

    div_sub_stage #(
        .N (N)
    ) u_sub (
        .shifted      (shifted),
        .divisor      (dvs_q),
        .partial_next (part_next),
        .q_bit        (q_bit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            dvd_sr_q <= '0;
            dvs_q    <= '0;
            part_q   <= '0;
            quot_q   <= '0;
            rem_q    <= '0;
            dz_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            dvd_sr_q <= dvd_sr_d;
            dvs_q    <= dvs_d;
            part_q   <= part_d;
            quot_q   <= quot_d;
            rem_q    <= rem_d;
            dz_q     <= dz_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        dvd_sr_d = dvd_sr_q;
        dvs_d    = dvs_q;
        part_d   = part_q;
        quot_d   = quot_q;
        rem_d    = rem_q;
        dz_d     = dz_q;
        if (en) begin
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        dvd_sr_d = dividend;
                        dvs_d    = divisor;
                        part_d   = '0;
                        cnt_d    = '0;
                        if (divisor == '0) begin
                            state_d = S_DONE;
                            quot_d  = '1;
                            rem_d   = dividend[N-1:0];
                            dz_d    = 1'b1;
                        end else begin
                            state_d = S_RUN;
                            quot_d  = '0;
                            rem_d   = '0;
                            dz_d    = 1'b0;
                        end
                    end
                end
                S_RUN: begin
                    part_d   = part_next;
                    quot_d   = {quot_q[2*N-2:0], q_bit};
                    dvd_sr_d = dvd_sr_q << 1;
                    if (cnt_q == LastIter) begin
                        state_d = S_DONE;
                        rem_d   = part_next;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_DONE: state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        busy = (state_q != S_IDLE);
        done = (state_q == S_DONE);
    end

    assign div_zero  = dz_q;
    assign quotient  = quot_q;
    assign remainder = rem_q;

endmodule
